regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port between NUM_REQ requesters (SHA-256 round
//  logic, message scheduler, loader, host) using round-robin arbitration and a
//  valid/ready handshake. It registers the granted write into ctrl_writeEnable,
//  ctrl_writeReg and data_writeReg, which drive the regfile write port directly. It also
//  publishes a one-hot pending-write vector so readers can detect RAW hazards.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  REG_W    5   register address width (32 registers)
//  DATA_W   32  write data width
// PORTS
//  clock             in   1              rising-edge clock
//  ctrl_reset_n      in   1              synchronous reset, active-low
//  req_valid         in   NUM_REQ        per-requester write request
//  req_reg           in   NUM_REQ*REG_W  target register; requester i at [i*REG_W +: REG_W]
//  req_data          in   NUM_REQ*DATA_W write data; requester i at [i*DATA_W +: DATA_W]
//  req_ready         out  NUM_REQ        one-hot grant; a write transfers on valid&ready
//  arb_hold          in   1              1 = grant nothing this cycle
//  ctrl_writeEnable  out  1              regfile write enable (registered)
//  ctrl_writeReg     out  REG_W          regfile write address (registered)
//  data_writeReg     out  DATA_W         regfile write data (registered)
//  wr_pending        out  32             one-hot of the register written this cycle; 0 if none
//  write_count       out  16             committed writes; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: ctrl_reset_n=0 at a clock edge clears ptr=0, ctrl_writeEnable=0,
//    ctrl_writeReg=0, data_writeReg=0 and write_count=0. While ctrl_reset_n=0, req_ready=0.
//  - Arbitration is combinational in the same cycle. Search req_valid starting at index
//    ptr, wrapping modulo NUM_REQ. The first valid index i gets req_ready[i]=1. Every
//    other bit is 0.
//  - No grant when arb_hold=1, when ctrl_reset_n=0, or when no req_valid bit is set.
//  - Handshake: a requester holds valid, reg and data stable until ready. ready may
//    depend on valid. Deasserting valid before ready is not allowed.
//  - Pointer: on a transfer from i, ptr <= (i+1) mod NUM_REQ. With no transfer, ptr holds.
//    arb_hold does not move ptr.
//  - Latency 1: a transfer in cycle t sets ctrl_writeReg and data_writeReg in cycle t+1.
//    ctrl_writeEnable=1 in t+1 only if req_reg != 0. Register 0 is hardwired zero, so the
//    write is accepted (ready=1) but suppressed (enable=0).
//  - Cycle with no transfer: ctrl_writeEnable <= 0. ctrl_writeReg and data_writeReg hold.
//  - Back-to-back grants are allowed every cycle, giving full port throughput.
//  - wr_pending = decode(ctrl_writeReg) gated by ctrl_writeEnable. It is combinational from
//    registered state.
//  - write_count increments on each cycle with ctrl_writeEnable=1 and stops at 16'hFFFF.
//    Suppressed r0 writes do not count.
//  - Reset mid-operation: any write in the output stage is dropped (enable=0 next cycle).
//    Arbitration restarts at requester 0.
//  - Same target register from several requesters: they are serialized by grant order.
//    The last granted write wins. No merging is done.
// STRUCTURE
//  - Shared package regfile_pkg: REG_W, DATA_W, NUM_REGS=32, REG_ZERO=0, CNT_W=16.
//  - Sub-module: the existing 5-to-32 `decoder` (out, select, enable) produces wr_pending
//    with select=ctrl_writeReg and enable=ctrl_writeEnable.
//  - Round-robin search is a function or generate loop over a doubled request vector.
//    It is not a separate module.
// TESTING
//  1. Reset: ctrl_reset_n=0 for 2 cycles with req_valid=4'hF
//     -> req_ready=0, ctrl_writeEnable=0, write_count=0, wr_pending=0.
//  2. Single requester: req1 writes reg 7 with 32'hDEADBEEF
//     -> req_ready=4'b0010 in the same cycle; next cycle ctrl_writeEnable=1,
//        ctrl_writeReg=7, data_writeReg=32'hDEADBEEF, wr_pending=32'h80, write_count=1.
//  3. Fairness: req_valid=4'hF held for 5 cycles
//     -> req_ready sequence 0001, 0010, 0100, 1000, 0001; writes land in that order.
//  4. r0 write: req2 writes reg 0 with 32'h12345678
//     -> req_ready[2]=1; next cycle ctrl_writeEnable=0, wr_pending=0, write_count unchanged.
//  5. Hold: after a grant to req0, set arb_hold=1 for 3 cycles with req_valid=4'b0011
//     -> req_ready=0 and enable=0 during the hold; on release req1 is granted first.
//  6. Reset mid-stream: pull ctrl_reset_n low in the cycle after req2's transfer, with
//     req_valid=4'hF
//     -> the req2 write is dropped (ctrl_writeEnable=0); after release req0 is granted.
//     Also preload write_count near 16'hFFFF and check it saturates.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants for the write arbiter slice
package regfile_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;
    localparam int CNT_W    = 16;

endpackage

// File: rtl/decoder.sv
// rtl/decoder.sv - binary-to-one-hot decoder with enable
module decoder #(
    parameter int SEL_W = 5
) (
    output logic [(2**SEL_W)-1:0] out,
    input  logic [SEL_W-1:0]      select,
    input  logic                  enable
);

    always_comb begin
        out = '0;
        if (enable) begin
            out[select] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the regfile write port
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REG_W   = regfile_pkg::REG_W,
    parameter int DATA_W  = regfile_pkg::DATA_W
) (
    input  logic                      clock,
    input  logic                      ctrl_reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_W-1:0]  req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      arb_hold,
    output logic                      ctrl_writeEnable,
    output logic [REG_W-1:0]          ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg,
    output logic [NUM_REGS-1:0]       wr_pending,
    output logic [CNT_W-1:0]          write_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       gidx;
    logic                   found;
    logic [2*NUM_REQ-1:0]   dbl;
    logic [NUM_REQ-1:0]     grant;
    logic [REG_W-1:0]       sel_reg;
    logic [DATA_W-1:0]      sel_data;
    logic [PTR_W-1:0]       ptr_next;

    // Doubling the request vector lets the search start at ptr and wrap without modulo logic.
    always_comb begin
        dbl   = {req_valid, req_valid};
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        if (ctrl_reset_n && !arb_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && dbl[int'(ptr) + k]) begin
                    found = 1'b1;
                    if (int'(ptr) + k >= NUM_REQ) begin
                        gidx = PTR_W'(int'(ptr) + k - NUM_REQ);
                    end else begin
                        gidx = PTR_W'(int'(ptr) + k);
                    end
                end
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign sel_reg   = req_reg[int'(gidx)*REG_W +: REG_W];
    assign sel_data  = req_data[int'(gidx)*DATA_W +: DATA_W];
    assign ptr_next  = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            ptr              <= '0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else if (found) begin
            ptr              <= ptr_next;
            ctrl_writeReg    <= sel_reg;
            data_writeReg    <= sel_data;
            // r0 is hardwired zero: accept the transfer but never enable the port
            ctrl_writeEnable <= (sel_reg != REG_W'(REG_ZERO));
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            write_count <= '0;
        end else if (ctrl_writeEnable && (write_count != {CNT_W{1'b1}})) begin
            write_count <= write_count + 1'b1;
        end
    end

    decoder #(
        .SEL_W (REG_W)
    ) u_pending_dec (
        .out    (wr_pending),
        .select (ctrl_writeReg),
        .enable (ctrl_writeEnable)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic         clock;
    logic         ctrl_reset_n;
    logic [3:0]   req_valid;
    logic [19:0]  req_reg;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         arb_hold;
    logic         ctrl_writeEnable;
    logic [4:0]   ctrl_writeReg;
    logic [31:0]  data_writeReg;
    logic [31:0]  wr_pending;
    logic [15:0]  write_count;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_write_arbiter #(
        .NUM_REQ (4),
        .REG_W   (5),
        .DATA_W  (32)
    ) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .req_valid        (req_valid),
        .req_reg          (req_reg),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .arb_hold         (arb_hold),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .wr_pending       (wr_pending),
        .write_count      (write_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        ctrl_reset_n = 1'b0;
        req_valid    = 4'hF;
        arb_hold     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_reg[i*5 +: 5]    = 5'(10 + i);
            req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        end
        tick();
        tick();
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", req_ready); else n_pass++;
        n_checks++; if (ctrl_writeEnable !== 1'b0) $display("FAIL reset_we got %b exp 0", ctrl_writeEnable); else n_pass++;
        n_checks++; if (write_count !== 16'h0) $display("FAIL reset_count got %h exp 0000", write_count); else n_pass++;
        n_checks++; if (wr_pending !== 32'h0) $display("FAIL reset_pending got %h exp 0", wr_pending); else n_pass++;
        ctrl_reset_n = 1'b1;
        req_valid    = 4'h0;
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_ready [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int         exp_idx   [5] = '{0, 1, 2, 3, 0};
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (req_ready !== exp_ready[k]) $display("FAIL fair_ready%0d got %b exp %b", k, req_ready, exp_ready[k]); else n_pass++;
            tick();
            n_checks++; if (ctrl_writeEnable !== 1'b1) $display("FAIL fair_we%0d got %b exp 1", k, ctrl_writeEnable); else n_pass++;
            n_checks++; if (ctrl_writeReg !== 5'(10 + exp_idx[k])) $display("FAIL fair_reg%0d got %0d exp %0d", k, ctrl_writeReg, 10 + exp_idx[k]); else n_pass++;
            n_checks++; if (data_writeReg !== 32'hA000_0000 + 32'(exp_idx[k])) $display("FAIL fair_data%0d got %h exp %h", k, data_writeReg, 32'hA000_0000 + 32'(exp_idx[k])); else n_pass++;
        end
        req_valid = 4'h0;
        tick();
        n_checks++; if (write_count !== 16'd5) $display("FAIL fair_count got %0d exp 5", write_count); else n_pass++;
    endtask

    task automatic test_single();
        req_reg[5 +: 5]    = 5'd7;
        req_data[32 +: 32] = 32'hDEADBEEF;
        req_valid          = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) $display("FAIL single_ready got %b exp 0010", req_ready); else n_pass++;
        tick();
        req_valid = 4'h0;
        n_checks++; if (ctrl_writeEnable !== 1'b1) $display("FAIL single_we got %b exp 1", ctrl_writeEnable); else n_pass++;
        n_checks++; if (ctrl_writeReg !== 5'd7) $display("FAIL single_reg got %0d exp 7", ctrl_writeReg); else n_pass++;
        n_checks++; if (data_writeReg !== 32'hDEADBEEF) $display("FAIL single_data got %h exp deadbeef", data_writeReg); else n_pass++;
        n_checks++; if (wr_pending !== 32'h80) $display("FAIL single_pending got %h exp 00000080", wr_pending); else n_pass++;
        tick();
        n_checks++; if (write_count !== 16'd6) $display("FAIL single_count got %0d exp 6", write_count); else n_pass++;
    endtask

    task automatic test_r0_write();
        req_reg[10 +: 5]   = 5'd0;
        req_data[64 +: 32] = 32'h12345678;
        req_valid          = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL r0_ready got %b exp 0100", req_ready); else n_pass++;
        tick();
        req_valid = 4'h0;
        n_checks++; if (ctrl_writeEnable !== 1'b0) $display("FAIL r0_we got %b exp 0", ctrl_writeEnable); else n_pass++;
        n_checks++; if (wr_pending !== 32'h0) $display("FAIL r0_pending got %h exp 0", wr_pending); else n_pass++;
        n_checks++; if (data_writeReg !== 32'h12345678) $display("FAIL r0_data got %h exp 12345678", data_writeReg); else n_pass++;
        tick();
        n_checks++; if (write_count !== 16'd6) $display("FAIL r0_count got %0d exp 6", write_count); else n_pass++;
    endtask

    task automatic test_hold();
        req_valid = 4'b0001;
        #1;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL hold_pre_ready got %b exp 0001", req_ready); else n_pass++;
        tick();
        arb_hold  = 1'b1;
        req_valid = 4'b0011;
        #1;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL hold_ready0 got %b exp 0000", req_ready); else n_pass++;
        for (int k = 1; k < 3; k++) begin
            tick();
            n_checks++; if (req_ready !== 4'b0000) $display("FAIL hold_ready%0d got %b exp 0000", k, req_ready); else n_pass++;
            n_checks++; if (ctrl_writeEnable !== 1'b0) $display("FAIL hold_we%0d got %b exp 0", k, ctrl_writeEnable); else n_pass++;
        end
        tick();
        arb_hold = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0010) $display("FAIL hold_release_ready got %b exp 0010", req_ready); else n_pass++;
        tick();
        req_valid = 4'h0;
        n_checks++; if (ctrl_writeReg !== 5'd7) $display("FAIL hold_release_reg got %0d exp 7", ctrl_writeReg); else n_pass++;
        tick();
        n_checks++; if (write_count !== 16'd8) $display("FAIL hold_count got %0d exp 8", write_count); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        req_reg[10 +: 5]   = 5'd5;
        req_data[64 +: 32] = 32'h55;
        req_valid          = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL mid_ready got %b exp 0100", req_ready); else n_pass++;
        tick();
        ctrl_reset_n = 1'b0;
        req_valid    = 4'hF;
        #1;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL mid_reset_ready got %b exp 0000", req_ready); else n_pass++;
        tick();
        n_checks++; if (ctrl_writeEnable !== 1'b0) $display("FAIL mid_we got %b exp 0", ctrl_writeEnable); else n_pass++;
        n_checks++; if (write_count !== 16'd0) $display("FAIL mid_count got %0d exp 0", write_count); else n_pass++;
        ctrl_reset_n = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL mid_restart_ready got %b exp 0001", req_ready); else n_pass++;
        tick();
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_saturate();
        ctrl_reset_n = 1'b0;
        tick();
        ctrl_reset_n     = 1'b1;
        req_reg[0 +: 5]  = 5'd3;
        req_valid        = 4'b0001;
        for (int i = 0; i < 65534; i++) begin
            @(posedge clock);
        end
        #1;
        req_valid = 4'h0;
        tick();
        tick();
        n_checks++; if (write_count !== 16'hFFFE) $display("FAIL sat_near got %h exp fffe", write_count); else n_pass++;
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
        end
        #1;
        req_valid = 4'h0;
        tick();
        tick();
        n_checks++; if (write_count !== 16'hFFFF) $display("FAIL sat_top got %h exp ffff", write_count); else n_pass++;
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        req_valid    = 4'h0;
        req_reg      = '0;
        req_data     = '0;
        arb_hold     = 1'b0;
        #1;
        test_reset();
        test_fairness();
        test_single();
        test_r0_write();
        test_hold();
        test_reset_midstream();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
